// File: rtl/controlador_mult_matrizes.sv
// -----------------------------------------------------------------------------
// controlador_mult_matrizes
//
// Sequential 5x5 signed int8 matrix multiplier C = A*B built around a single
// multiply-accumulate. Operands are latched when a run is accepted. Each
// element takes 5 MAC cycles plus 1 WRITE cycle, and elements are produced in
// row-major order.
//
// Optional feature: define SATURACAO_EN to clamp out-of-range elements to
// +127 / -128. Without it, such elements keep the low 8 bits of the
// accumulator (two's-complement wrap). overflow_flag behaves the same in both
// builds.
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   start         run request, sampled only in IDLE
//   A, B          5x5 int8 matrices, element [i][k] at bits (i*40+k*8)+:8
//   C             registered result matrix, same layout
//   overflow_flag sticky: some element of the current run left [-128,127]
//   busy          high from the cycle after acceptance until DONE is left
//   done          one-cycle pulse when C is complete
// -----------------------------------------------------------------------------
module controlador_mult_matrizes #(
    parameter int W_ACC = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [199:0] A,
    input  logic [199:0] B,
    output logic [199:0] C,
    output logic         overflow_flag,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} state_t;

    localparam logic signed [W_ACC-1:0] ACC_MAX = W_ACC'(127);
    localparam logic signed [W_ACC-1:0] ACC_MIN = W_ACC'(-128);

    state_t                   state_q, state_d;
    logic [199:0]             a_q, a_d;
    logic [199:0]             b_q, b_d;
    logic [7:0]               c_el_q [25];
    logic [7:0]               c_el_d [25];
    logic signed [W_ACC-1:0]  acc_q, acc_d;
    logic [2:0]               i_q, i_d;
    logic [2:0]               j_q, j_d;
    logic [2:0]               k_q, k_d;
    logic                     ovf_q, ovf_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    // Element views of the latched operands; flat index is row*5 + col.
    logic signed [7:0] a_el [25];
    logic signed [7:0] b_el [25];

    genvar gi;
    generate
        for (gi = 0; gi < 25; gi++) begin : g_el
            assign a_el[gi]        = a_q[gi*8 +: 8];
            assign b_el[gi]        = b_q[gi*8 +: 8];
            assign C[gi*8 +: 8]    = c_el_q[gi];
        end
    endgenerate

    logic [4:0]               a_idx, b_idx, w_idx;
    logic signed [7:0]        a_sel, b_sel;
    logic signed [15:0]       prod;
    logic                     acc_out_of_range;
    logic [7:0]               wr_val;

    always_comb begin
        a_idx = {2'b00, i_q} * 5'd5 + {2'b00, k_q};
        b_idx = {2'b00, k_q} * 5'd5 + {2'b00, j_q};
        w_idx = {2'b00, i_q} * 5'd5 + {2'b00, j_q};
        a_sel = a_el[a_idx];
        b_sel = b_el[b_idx];
        prod  = a_sel * b_sel;
        acc_out_of_range = (acc_q > ACC_MAX) || (acc_q < ACC_MIN);
    end

    // Value stored for the element currently in the accumulator.
    always_comb begin
`ifdef SATURACAO_EN
        if (acc_q > ACC_MAX) begin
            wr_val = 8'h7f;
        end else if (acc_q < ACC_MIN) begin
            wr_val = 8'h80;
        end else begin
            wr_val = acc_q[7:0];
        end
`else
        wr_val = acc_q[7:0];
`endif
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_el_d  = c_el_q;
        acc_d   = acc_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d    = A;
                    b_d    = B;
                    for (int n = 0; n < 25; n++) c_el_d[n] = '0;
                    ovf_d  = 1'b0;
                    acc_d  = '0;
                    i_d    = '0;
                    j_d    = '0;
                    k_d    = '0;
                    busy_d = 1'b1;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = acc_q + W_ACC'(prod);
                if (k_q == 3'd4) begin
                    state_d = WRITE;
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
            WRITE: begin
                c_el_d[w_idx] = wr_val;
                if (acc_out_of_range) ovf_d = 1'b1;
                acc_d   = '0;
                k_d     = '0;
                state_d = MAC;
                if (j_q == 3'd4) begin
                    j_d = '0;
                    if (i_q == 3'd4) begin
                        // Last element: done is registered so it is high for
                        // exactly the one cycle spent in DONE.
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        i_d = i_q + 3'd1;
                    end
                end else begin
                    j_d = j_q + 3'd1;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            for (int n = 0; n < 25; n++) c_el_q[n] <= '0;
            acc_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_el_q  <= c_el_d;
            acc_q   <= acc_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign overflow_flag = ovf_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_controlador_mult_matrizes.sv
// -----------------------------------------------------------------------------
// tb_controlador_mult_matrizes
//
// Scoreboard bench: each accepted run pushes its expected C, overflow flag and
// done cycle; the monitor pops and compares on every done pulse, and checks
// that busy/done fall in the following cycle.
// -----------------------------------------------------------------------------
module tb_controlador_mult_matrizes;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [199:0] a_in, b_in;
    logic [199:0] c_out;
    logic         overflow_flag, busy, done;

    controlador_mult_matrizes #(.W_ACC(20)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .A             (a_in),
        .B             (b_in),
        .C             (c_out),
        .overflow_flag (overflow_flag),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [199:0] c;
        logic         ovf;
        int           done_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s obs=%0h exp=%0h", tag, obs, expv);
    endtask

    // Reference: plain integer matrix product, then range handling.
    function automatic exp_t model(input logic [199:0] a, input logic [199:0] b, input int dc);
        exp_t e;
        int   s;
        logic signed [7:0] av, bv;
        logic [31:0] sv;
        e.c = '0;
        e.ovf = 1'b0;
        e.done_cyc = dc;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 5; j++) begin
                s = 0;
                for (int k = 0; k < 5; k++) begin
                    av = a[i*40+k*8 +: 8];
                    bv = b[k*40+j*8 +: 8];
                    s += int'(av) * int'(bv);
                end
                if (s > 127 || s < -128) e.ovf = 1'b1;
`ifdef SATURACAO_EN
                if (s > 127) s = 127;
                else if (s < -128) s = -128;
`endif
                sv = s;
                e.c[i*40+j*8 +: 8] = sv[7:0];
            end
        end
        return e;
    endfunction

    function automatic logic [199:0] ident(input logic [7:0] v);
        logic [199:0] m = '0;
        for (int i = 0; i < 5; i++) m[i*40+i*8 +: 8] = v;
        return m;
    endfunction

    function automatic logic [199:0] fill(input logic [7:0] v);
        logic [199:0] m;
        for (int n = 0; n < 25; n++) m[n*8 +: 8] = v;
        return m;
    endfunction

    function automatic logic [199:0] rnd_mat();
        logic [199:0] m;
        for (int n = 0; n < 25; n++) m[n*8 +: 8] = 8'($urandom_range(0, 255));
        return m;
    endfunction

    // Monitor: one line per completed run.
    logic done_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            done_prev = 1'b0;
        end else begin
            if (done_prev) begin
                chk("busy_fall", {199'd0, busy}, 200'd0);
                chk("done_width", {199'd0, done}, 200'd0);
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_done", {199'd0, done}, 200'd0);
                end else begin
                    e = exp_q.pop_front();
                    $display("run done at cycle %0d: C=%0h ovf=%0b", cyc, c_out, overflow_flag);
                    chk("C", c_out, e.c);
                    chk("ovf", {199'd0, overflow_flag}, {199'd0, e.ovf});
                    chk("done_cyc", 200'(cyc), 200'(e.done_cyc));
                    chk("busy_at_done", {199'd0, busy}, 200'd1);
                end
            end
            done_prev = done;
        end
    end

    // Start a run from IDLE; acceptance edge is the next posedge (cyc+1).
    task automatic launch(input logic [199:0] a, input logic [199:0] b);
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        exp_q.push_back(model(a, b, cyc + 1 + 150));
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", {199'd0, busy}, 200'd1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("timeout", 200'(exp_q.size()), 200'd0);
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [199:0] m, a1, a2, bb;
        int c0;

        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_C", c_out, 200'd0);
        chk("rst_ovf", {199'd0, overflow_flag}, 200'd0);
        chk("rst_busy", {199'd0, busy}, 200'd0);
        chk("rst_done", {199'd0, done}, 200'd0);

        // Identity times B[i][j] = i+j; A altered right after acceptance.
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                m[i*40+j*8 +: 8] = 8'(i + j);
        launch(ident(8'd1), m);
        a_in = rnd_mat();
        b_in = rnd_mat();
        wait_idle(400);

        // Every element overflows.
        launch(fill(8'd127), fill(8'd127));
        wait_idle(400);

        // -128 * identity stays in range.
        launch(fill(8'h80), ident(8'd1));
        wait_idle(400);

        // Random operands, two runs.
        for (int r = 0; r < 2; r++) begin
            launch(rnd_mat(), rnd_mat());
            wait_idle(400);
        end

        // Reset mid-run aborts it; a fresh run follows.
        launch(fill(8'd127), fill(8'd127));
        repeat (39) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        chk("abort_C", c_out, 200'd0);
        chk("abort_busy", {199'd0, busy}, 200'd0);
        launch(ident(8'd2), fill(8'd3));
        wait_idle(400);

        // start held for 400 cycles: runs back-to-back every 152 cycles,
        // each using the A present at its own acceptance.
        a1 = rnd_mat();
        a2 = rnd_mat();
        bb = rnd_mat();
        @(negedge clk);
        c0    = cyc;
        a_in  = ident(8'd1);
        b_in  = bb;
        start = 1'b1;
        exp_q.push_back(model(ident(8'd1), bb, c0 + 1 + 150));
        exp_q.push_back(model(a1, bb, c0 + 1 + 152 + 150));
        exp_q.push_back(model(a2, bb, c0 + 1 + 304 + 150));
        repeat (50) @(negedge clk);
        a_in = a1;
        repeat (150) @(negedge clk);
        a_in = a2;
        repeat (200) @(negedge clk);
        start = 1'b0;
        wait_idle(400);
        chk("no_extra_run", {199'd0, busy}, 200'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
